// File: rtl/ar_channel_arbiter.sv
// Round-robin AR channel arbiter: grants one requester at a time and writes its
// payload, ID-tagged with the grant index, into the AR buffer under an in-flight cap.
module ar_channel_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int BURST_TYPE      = 2,
  parameter int BURST_LEN       = 8,
  parameter int BEAT_SIZE       = 3,
  parameter int ID              = 5,
  parameter int MAX_OUTSTANDING = 8,
  localparam int MIDX_W         = $clog2(NUM_MASTERS),
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              AR_arb_clk,
  input  logic                              AR_arb_rst,
  input  logic [NUM_MASTERS-1:0]            in_ARVALID,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] in_ARADDR,
  input  logic [NUM_MASTERS*BURST_TYPE-1:0] in_ARBURST,
  input  logic [NUM_MASTERS*BURST_LEN-1:0]  in_ARLEN,
  input  logic [NUM_MASTERS*BEAT_SIZE-1:0]  in_ARSIZE,
  input  logic [NUM_MASTERS*ID-1:0]         in_ARID,
  output logic [NUM_MASTERS-1:0]            out_ARREADY,
  output logic [ADDR_WIDTH-1:0]             out_fifo_ARADDR,
  output logic [BURST_TYPE-1:0]             out_fifo_ARBURST,
  output logic [BURST_LEN-1:0]              out_fifo_ARLEN,
  output logic [BEAT_SIZE-1:0]              out_fifo_ARSIZE,
  output logic [ID+MIDX_W-1:0]              out_fifo_ARID,
  output logic                              out_fifo_ARVALID,
  output logic                              AR_fifo_w_en,
  input  logic                              AR_fifo_full,
  input  logic                              rd_burst_done,
  output logic [MIDX_W-1:0]                 grant_idx,
  output logic [CNT_W-1:0]                  outstanding_cnt,
  output logic                              cnt_underflow_err
);

  // state | meaning
  // IDLE  | arbitrate among requesters, grant at most one
  // ISSUE | hold payload on the buffer write port until it is accepted
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state;
  logic [MIDX_W-1:0]  last_grant;
  logic [MIDX_W-1:0]  win_idx;
  logic               win_found;
  logic               eligible;
  logic               issue_done;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BURST_TYPE-1:0] sel_burst;
  logic [BURST_LEN-1:0]  sel_len;
  logic [BEAT_SIZE-1:0]  sel_size;
  logic [ID-1:0]         sel_id;

  // Rotating priority: scan from last_grant+1 upward with wrap.
  always_comb begin
    int               cand;
    logic [MIDX_W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand     = (int'(last_grant) + i) % NUM_MASTERS;
      cand_idx = MIDX_W'(cand);
      if (!win_found && in_ARVALID[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_burst = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_id    = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (win_idx == MIDX_W'(m)) begin
        sel_addr  = in_ARADDR[m*ADDR_WIDTH +: ADDR_WIDTH];
        sel_burst = in_ARBURST[m*BURST_TYPE +: BURST_TYPE];
        sel_len   = in_ARLEN[m*BURST_LEN +: BURST_LEN];
        sel_size  = in_ARSIZE[m*BEAT_SIZE +: BEAT_SIZE];
        sel_id    = in_ARID[m*ID +: ID];
      end
    end
  end

  // Cap uses the registered count, so a same-cycle decrement cannot open a grant.
  assign eligible   = !AR_arb_rst && (state == IDLE) && win_found &&
                      (outstanding_cnt < CNT_W'(MAX_OUTSTANDING));
  assign issue_done = (state == ISSUE) && !AR_fifo_full;

  always_comb begin
    out_ARREADY = '0;
    if (eligible) out_ARREADY[win_idx] = 1'b1;
  end

  always_ff @(posedge AR_arb_clk) begin
    if (AR_arb_rst) begin
      state             <= IDLE;
      last_grant        <= MIDX_W'(NUM_MASTERS - 1);
      grant_idx         <= '0;
      out_fifo_ARADDR   <= '0;
      out_fifo_ARBURST  <= '0;
      out_fifo_ARLEN    <= '0;
      out_fifo_ARSIZE   <= '0;
      out_fifo_ARID     <= '0;
      out_fifo_ARVALID  <= 1'b0;
      AR_fifo_w_en      <= 1'b0;
      outstanding_cnt   <= '0;
      cnt_underflow_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (eligible) begin
            state            <= ISSUE;
            last_grant       <= win_idx;
            grant_idx        <= win_idx;
            out_fifo_ARADDR  <= sel_addr;
            out_fifo_ARBURST <= sel_burst;
            out_fifo_ARLEN   <= sel_len;
            out_fifo_ARSIZE  <= sel_size;
            out_fifo_ARID    <= {win_idx, sel_id};
            out_fifo_ARVALID <= 1'b1;
            AR_fifo_w_en     <= 1'b1;
          end
        end
        ISSUE: begin
          if (!AR_fifo_full) begin
            state            <= IDLE;
            out_fifo_ARVALID <= 1'b0;
            AR_fifo_w_en     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (issue_done && !rd_burst_done) begin
        outstanding_cnt <= outstanding_cnt + CNT_W'(1);
      end else if (rd_burst_done && !issue_done) begin
        if (outstanding_cnt == '0) cnt_underflow_err <= 1'b1;
        else                       outstanding_cnt   <= outstanding_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ar_channel_arbiter.sv
// Bench for ar_channel_arbiter: directed scenarios plus randomized traffic, all
// checked each cycle against a transaction-level reference model.
module tb_ar_channel_arbiter;
  localparam int N = 4, AW = 32, IW = 5, MW = 2, CW = 4, MAXO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, full, done;
  logic [N-1:0]  v;
  logic [AW-1:0] a  [N];
  logic [1:0]    b  [N];
  logic [7:0]    l  [N];
  logic [2:0]    s  [N];
  logic [IW-1:0] id [N];

  logic [N*AW-1:0] p_addr;
  logic [N*2-1:0]  p_burst;
  logic [N*8-1:0]  p_len;
  logic [N*3-1:0]  p_size;
  logic [N*IW-1:0] p_id;

  always_comb begin
    for (int m = 0; m < N; m++) begin
      p_addr[m*AW +: AW]  = a[m];
      p_burst[m*2 +: 2]   = b[m];
      p_len[m*8 +: 8]     = l[m];
      p_size[m*3 +: 3]    = s[m];
      p_id[m*IW +: IW]    = id[m];
    end
  end

  logic [N-1:0]     out_ARREADY;
  logic [AW-1:0]    f_addr;
  logic [1:0]       f_burst;
  logic [7:0]       f_len;
  logic [2:0]       f_size;
  logic [IW+MW-1:0] f_id;
  logic             f_valid, w_en;
  logic [MW-1:0]    grant_idx;
  logic [CW-1:0]    cnt;
  logic             err;

  ar_channel_arbiter dut (
    .AR_arb_clk(clk), .AR_arb_rst(rst),
    .in_ARVALID(v), .in_ARADDR(p_addr), .in_ARBURST(p_burst),
    .in_ARLEN(p_len), .in_ARSIZE(p_size), .in_ARID(p_id),
    .out_ARREADY(out_ARREADY),
    .out_fifo_ARADDR(f_addr), .out_fifo_ARBURST(f_burst), .out_fifo_ARLEN(f_len),
    .out_fifo_ARSIZE(f_size), .out_fifo_ARID(f_id), .out_fifo_ARVALID(f_valid),
    .AR_fifo_w_en(w_en), .AR_fifo_full(full), .rd_burst_done(done),
    .grant_idx(grant_idx), .outstanding_cnt(cnt), .cnt_underflow_err(err)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pending transfer slot, a priority pointer and a counter.
  bit               m_busy, m_err;
  int               m_last, m_gidx, m_cnt, w;
  logic [AW-1:0]    m_addr;
  logic [IW+MW-1:0] m_id;
  logic [12:0]      m_bls;
  logic [N-1:0]     exp_rdy;

  task automatic mdl_reset();
    m_busy = 0; m_err = 0; m_last = N - 1; m_gidx = 0; m_cnt = 0;
    m_addr = '0; m_id = '0; m_bls = '0;
  endtask

  // Inputs are set at the falling edge; check, then advance across one rising edge.
  task automatic step();
    bit inc;
    #1;
    exp_rdy = '0;
    w = -1;
    if (!rst && !m_busy && v != 0 && m_cnt < MAXO) begin
      for (int k = 1; k <= N; k++)
        if (w < 0 && v[(m_last + k) % N]) w = (m_last + k) % N;
      exp_rdy[w] = 1'b1;
    end
    check_eq("ready", out_ARREADY, exp_rdy);
    check_eq("fifo_valid", f_valid, m_busy);
    check_eq("w_en", w_en, m_busy);
    check_eq("addr", f_addr, m_addr);
    check_eq("arid", f_id, m_id);
    check_eq("burst_len_size", {f_burst, f_len, f_size}, m_bls);
    check_eq("cnt", cnt, m_cnt);
    check_eq("underflow", err, m_err);
    check_eq("grant_idx", grant_idx, m_gidx);
    @(posedge clk);
    if (rst) mdl_reset();
    else begin
      inc = m_busy && !full;
      if (exp_rdy != 0) begin
        m_busy = 1; m_last = w; m_gidx = w;
        m_addr = a[w]; m_id = {w[MW-1:0], id[w]}; m_bls = {b[w], l[w], s[w]};
      end else if (inc) m_busy = 0;
      if (inc && !done) m_cnt++;
      else if (done && !inc) begin
        if (m_cnt == 0) m_err = 1;
        else m_cnt--;
      end
    end
    @(negedge clk);
  endtask

  task automatic new_req(input int m);
    v[m] = 1'($urandom_range(0, 1));
    a[m] = $urandom; b[m] = 2'($urandom); l[m] = 8'($urandom);
    s[m] = 3'($urandom); id[m] = IW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    mdl_reset();
    rst = 1; full = 0; done = 0; v = '0;
    for (int m = 0; m < N; m++) begin
      a[m] = '0; b[m] = '0; l[m] = '0; s[m] = '0; id[m] = '0;
    end
    @(negedge clk);
    step(); step();
    rst = 0;

    // Lone request from master 2.
    v = 4'b0100; a[2] = 32'h1000_0040; id[2] = 5'h03; b[2] = 2'd1; l[2] = 8'd7; s[2] = 3'd2;
    #1 check_eq("t1_ready", out_ARREADY, 4'b0100);
    step();
    v = '0;
    check_eq("t1_arid", f_id, 7'b10_00011);
    check_eq("t1_wen", w_en, 1);
    step();
    check_eq("t1_cnt", cnt, 1);

    // Round-robin order with all masters requesting.
    do_reset();
    for (int m = 0; m < N; m++) new_req(m);
    v = '1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("rr_order", grant_idx, k % N);
      done = 1; step(); done = 0;
    end

    // Backpressure from a full buffer during ISSUE.
    step();
    full = 1;
    repeat (5) begin
      step();
      check_eq("full_no_ready", out_ARREADY, 0);
    end
    full = 0;
    step();
    check_eq("full_released", w_en, 0);

    // Outstanding cap.
    do_reset();
    v = '1;
    repeat (16) step();
    check_eq("cap_cnt", cnt, 8);
    step();
    check_eq("cap_ready", out_ARREADY, 0);
    done = 1; step(); done = 0;
    check_eq("cap_cnt_dec", cnt, 7);
    check_eq("cap_regrant", |out_ARREADY, 1);
    step(); step();

    // Coincident increment/decrement, then underflow.
    do_reset();
    repeat (6) step();
    step(); done = 1; step(); done = 0;
    check_eq("coincident_cnt", cnt, 3);
    do_reset();
    v = '0; done = 1; step(); done = 0;
    check_eq("underflow_flag", err, 1);
    check_eq("underflow_cnt", cnt, 0);

    // Reset during a stalled ISSUE.
    do_reset();
    v = '1; step();
    full = 1; step();
    rst = 1; step(); rst = 0;
    check_eq("rst_wen", w_en, 0);
    check_eq("rst_valid", f_valid, 0);
    check_eq("rst_cnt", cnt, 0);
    full = 0; step();
    check_eq("rst_first_grant", grant_idx, 0);

    // Randomized traffic; requesters hold until granted.
    do_reset();
    for (int m = 0; m < N; m++) new_req(m);
    repeat (3000) begin
      for (int m = 0; m < N; m++) if (!v[m] || exp_rdy[m]) new_req(m);
      full = ($urandom_range(0, 9) < 3);
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ar_channel_arbiter.md
# ar_channel_arbiter

Round-robin arbiter and issue sequencer for the AXI read-address (AR) channel. It accepts AR requests from NUM_MASTERS requesters and forwards one at a time into the write side of the AR buffer. Each forwarded ARID is tagged with the winning requester index. The number of in-flight read bursts is capped at MAX_OUTSTANDING. It sits between the master-side AR ports and the AR buffer, in the AR buffer's write-clock domain.

## Interface
- NUM_MASTERS, 4, number of requesters (≥2)
- ADDR_WIDTH, 32, ARADDR width
- BURST_TYPE, 2, ARBURST width
- BURST_LEN, 8, ARLEN width
- BEAT_SIZE, 3, ARSIZE width
- ID, 5, per-master ARID width
- MAX_OUTSTANDING, 8, maximum issued-but-uncompleted bursts (≥1)
- MIDX_W (local), $clog2(NUM_MASTERS), requester index width

Ports:
- AR_arb_clk  in  1  single clock; all logic on rising edge
- AR_arb_rst  in  1  reset, synchronous, active-high
- in_ARVALID  in  NUM_MASTERS  per-master request valid
- in_ARADDR  in  NUM_MASTERS*ADDR_WIDTH  packed; master m at [m*ADDR_WIDTH +: ADDR_WIDTH]
- in_ARBURST, in_ARLEN, in_ARSIZE, in_ARID  in  NUM_MASTERS*(field width)  packed the same way
- out_ARREADY  out  NUM_MASTERS  per-master ready, at most one bit high
- out_fifo_ARADDR/ARBURST/ARLEN/ARSIZE  out  field widths  registered payload to the AR buffer
- out_fifo_ARID  out  ID+MIDX_W  {grant index, master ARID}
- out_fifo_ARVALID  out  1  payload valid
- AR_fifo_w_en  out  1  AR buffer write enable
- AR_fifo_full  in  1  AR buffer full
- rd_burst_done  in  1  one-cycle pulse per completed read burst (RLAST handshake)
- grant_idx  out  MIDX_W  index of the last accepted master
- outstanding_cnt  out  $clog2(MAX_OUTSTANDING+1)  in-flight burst count
- cnt_underflow_err  out  1  sticky error flag

## Operation
- FSM states: IDLE and ISSUE.
- IDLE, arbitration:
  - Eligible when at least one in_ARVALID is high and outstanding_cnt < MAX_OUTSTANDING.
  - Winner: the first requesting master scanning from (last_grant+1) mod NUM_MASTERS upward, with wrap.
  - out_ARREADY[winner] is driven combinationally high in the same cycle. The handshake completes at that edge.
  - At the edge: winner payload is captured into the out_fifo_* registers, out_fifo_ARID = {winner, in_ARID[winner]}, last_grant and grant_idx ← winner, and the FSM moves to ISSUE.
  - If not eligible, all out_ARREADY stay low and the FSM stays in IDLE.
- ISSUE, transfer to buffer:
  - out_fifo_ARVALID and AR_fifo_w_en are held at 1 and the payload is held stable.
  - out_ARREADY is all zero.
  - On an edge with AR_fifo_full == 0: the write occurs, outstanding_cnt increments, and the FSM returns to IDLE.
  - While AR_fifo_full is high, the FSM waits indefinitely.
- AR_fifo_full is not checked in IDLE. Buffer backpressure is absorbed only in ISSUE.
- Outstanding counter:
  - +1 on ISSUE completion; −1 on rd_burst_done.
  - Both on the same edge: counter unchanged.
  - rd_burst_done while the counter is 0 (and no simultaneous increment): counter stays 0 and cnt_underflow_err is set. The flag clears only on reset.
  - The counter never exceeds MAX_OUTSTANDING.
- Requesters must hold valid and payload until they see ready. A requester that drops valid before being granted loses its turn without penalty.

## Timing
- Reset (AR_arb_rst high at an edge), applied to every register including mid-ISSUE:
  - State ← IDLE; an in-progress ISSUE is abandoned and nothing is written.
  - out_fifo_* payload ← 0; out_fifo_ARVALID ← 0; AR_fifo_w_en ← 0.
  - outstanding_cnt ← 0; cnt_underflow_err ← 0; grant_idx ← 0.
  - last_grant ← NUM_MASTERS−1, so master 0 has first priority.
  - out_ARREADY is forced to 0 while reset is high.
- Latency: master handshake at edge N; out_fifo_ARVALID and AR_fifo_w_en are high during cycle N+1; buffer write at edge N+1 if not full.
- Peak throughput: one request per 2 cycles. The IDLE cycle after each ISSUE is mandatory.
- out_ARREADY is a combinational function of registered state, in_ARVALID and outstanding_cnt only. It does not depend on AR_fifo_full.
- A decrement arriving in IDLE on the same edge as the cap is lifted does not enable a grant in that cycle. The cap check uses the registered count.

## Test plan
- Reset, then master 2 alone requests ARADDR=0x1000_0040, ARID=5'h03:
  - out_ARREADY=4'b0100 in the request cycle.
  - Next cycle: out_fifo_ARID=7'b10_00011 and AR_fifo_w_en=1.
  - outstanding_cnt=1 afterwards.
- All 4 masters hold valid continuously with rd_burst_done pulsed after each issue:
  - Grant order is 0,1,2,3,0,1…
  - A new AR_fifo_w_en pulse occurs every 2 cycles.
- AR_fifo_full held high for 5 cycles during ISSUE:
  - out_fifo_ARVALID stays high and the payload stays stable for 5 cycles.
  - No new out_ARREADY is raised.
  - The write completes on the first edge after full drops.
- Issue 8 requests with no rd_burst_done:
  - outstanding_cnt=8; a 9th valid sees out_ARREADY=0.
  - One rd_burst_done pulse → count 7 → the 9th request is granted in the following cycle.
- rd_burst_done coincident with ISSUE completion at count=3 → count stays 3. rd_burst_done at count 0 → count stays 0 and cnt_underflow_err=1.
- Assert AR_arb_rst during ISSUE with the buffer full:
  - No write occurs, outputs return to 0, and the count is 0.
  - The next arbitration grants master 0 first.
